// File: rtl/adc_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the dual-channel 14-bit ADC capture engine.
//   ADC_BITS       : width of one channel result
//   ADC_FRAME_LEN  : SCK periods in one serial frame
//   CH0_FIRST/CH1_FIRST : frame bit index of each channel's MSB
//   adc_state_t    : capture sequencer states
//   bit_in_field() : true when a frame bit index belongs to a channel field
// -----------------------------------------------------------------------------
package adc_pkg;

    localparam int ADC_BITS      = 14;
    localparam int ADC_FRAME_LEN = 34;
    localparam int CH0_FIRST     = 2;
    localparam int CH1_FIRST     = 18;

    // Bit counter must hold one past the last index (it increments on the
    // final falling edge while the sequencer leaves SHIFT).
    localparam int BIT_CNT_W = $clog2(ADC_FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } adc_state_t;

    function automatic logic bit_in_field(input logic [BIT_CNT_W-1:0] bit_idx,
                                          input int                   first);
        return (int'(bit_idx) >= first) && (int'(bit_idx) < first + ADC_BITS);
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_sck_gen
// Enableable SCK divider. While en is low the divider is held cleared and sck
// stays low; once enabled, sck toggles every SCK_HALF clock cycles, starting
// with a low half-period.
// Ports:
//   CLK50MHZ  : system clock (rising edge)
//   RST       : asynchronous active-low reset
//   en        : run enable; low forces the divider back to its start point
//   sck       : divided serial clock (registered, idles low)
//   rise_tick : high in the cycle whose closing edge drives sck high
//   fall_tick : high in the cycle whose closing edge drives sck low
// -----------------------------------------------------------------------------
module adc_sck_gen #(
    parameter int SCK_HALF = 2
) (
    input  logic CLK50MHZ,
    input  logic RST,
    input  logic en,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CNT_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_HALF - 1);

    logic [CNT_W-1:0] div_cnt_reg;
    logic             sck_reg;
    logic             half_done;

    // Ticks are combinational so the parent can act on the very edge where
    // sck changes (e.g. leave SHIFT exactly on the last falling edge).
    assign half_done = en && (div_cnt_reg == HALF_LAST);
    assign rise_tick = half_done && !sck_reg;
    assign fall_tick = half_done && sck_reg;
    assign sck       = sck_reg;

    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
        end else if (!en) begin
            div_cnt_reg <= '0;
            sck_reg     <= 1'b0;
        end else if (half_done) begin
            div_cnt_reg <= '0;
            sck_reg     <= ~sck_reg;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// adc_capture
// Capture engine for the dual-channel 14-bit ADC behind the preamplifier.
// On an accepted trigger it raises the conversion strobe for 2*SCK_HALF
// cycles, clocks a 34-bit serial frame, extracts both channels and presents
// them as two's-complement words with a one-cycle valid strobe.
// Ports:
//   CLK50MHZ  : system clock (rising edge)
//   RST       : asynchronous active-low reset
//   amp_ready : preamp gain loaded; triggers ignored while low
//   adc_trig  : single-cycle conversion request
//   adc_busy  : high from trigger acceptance until the cycle after adc_valid
//   adc_valid : one-cycle strobe, adc_ch0/adc_ch1 update in the same cycle
//   adc_ch0   : channel-0 result (two's complement)
//   adc_ch1   : channel-1 result (two's complement)
//   adc_conv  : ADC conversion strobe, active high
//   spi_sck   : serial clock to the ADC, idles low
//   spi_miso  : serial data from the ADC, changes on SCK falling edges
// All outputs come straight from flops; each lags the sequencer state by one
// clock.
// -----------------------------------------------------------------------------
module adc_capture
    import adc_pkg::*;
#(
    parameter int SCK_HALF  = 2,
    parameter int FRAME_LEN = 34
) (
    input  logic                       CLK50MHZ,
    input  logic                       RST,
    input  logic                       amp_ready,
    input  logic                       adc_trig,
    output logic                       adc_busy,
    output logic                       adc_valid,
    output logic signed [ADC_BITS-1:0] adc_ch0,
    output logic signed [ADC_BITS-1:0] adc_ch1,
    output logic                       adc_conv,
    output logic                       spi_sck,
    input  logic                       spi_miso
);

    localparam int CONV_CYCLES = 2 * SCK_HALF;
    localparam int CONV_W      = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam logic [CONV_W-1:0]    CONV_LAST = CONV_W'(CONV_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_LEN - 1);

    adc_state_t state_reg;
    adc_state_t state_next;

    logic [CONV_W-1:0]    conv_cnt_reg;
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic                 sample_en_reg;
    logic                 busy_reg;
    logic                 conv_reg;
    logic                 valid_reg;
    logic                 spi_sck_reg;

    logic sck_en;
    logic load_out;
    logic sck_int;
    logic rise_tick;
    logic fall_tick;

    assign sck_en   = (state_reg == ST_SHIFT);
    assign load_out = (state_reg == ST_DONE);

    // -------------------------------------------------------------------------
    // SCK divider, held cleared outside SHIFT so every frame starts with a
    // full low half-period.
    // -------------------------------------------------------------------------
    adc_sck_gen #(
        .SCK_HALF (SCK_HALF)
    ) u_sck_gen (
        .CLK50MHZ  (CLK50MHZ),
        .RST       (RST),
        .en        (sck_en),
        .sck       (sck_int),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // busy_reg still reflects the DONE cycle one clock after the
            // sequencer is back in IDLE; gating on it keeps a trigger from
            // being taken while adc_busy is visibly high.
            ST_IDLE:  if (adc_trig && amp_ready && !busy_reg) state_next = ST_CONV;
            ST_CONV:  if (conv_cnt_reg == CONV_LAST) state_next = ST_SHIFT;
            ST_SHIFT: if (fall_tick && (bit_cnt_reg == LAST_BIT)) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Conversion-width and frame-bit counters
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            conv_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            sample_en_reg <= 1'b0;
        end else begin
            conv_cnt_reg <= (state_reg == ST_CONV) ? conv_cnt_reg + 1'b1 : '0;
            if (!sck_en) begin
                bit_cnt_reg <= '0;
            end else if (fall_tick) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            // MISO is taken one clock after the internal SCK rises, which is
            // the edge where spi_sck rises at the pin: a full half-period
            // after the ADC last changed the data, even with SCK_HALF=1.
            sample_en_reg <= rise_tick;
        end
    end

    // -------------------------------------------------------------------------
    // Output flops
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK50MHZ or negedge RST) begin
        if (!RST) begin
            busy_reg    <= 1'b0;
            conv_reg    <= 1'b0;
            valid_reg   <= 1'b0;
            spi_sck_reg <= 1'b0;
        end else begin
            busy_reg    <= (state_reg != ST_IDLE);
            conv_reg    <= (state_reg == ST_CONV);
            valid_reg   <= load_out;
            spi_sck_reg <= sck_int;
        end
    end

    assign adc_busy  = busy_reg;
    assign adc_conv  = conv_reg;
    assign adc_valid = valid_reg;
    assign spi_sck   = spi_sck_reg;

    // -------------------------------------------------------------------------
    // Per-channel deserialiser and result register. The result is only
    // loaded from DONE, so an aborted frame never reaches the outputs.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            localparam int FIRST = (gi == 0) ? CH0_FIRST : CH1_FIRST;

            logic [ADC_BITS-1:0] shift_reg;
            logic [ADC_BITS-1:0] word_reg;
            logic                take_bit;

            assign take_bit = sample_en_reg && bit_in_field(bit_cnt_reg, FIRST);

            always_ff @(posedge CLK50MHZ or negedge RST) begin
                if (!RST) begin
                    shift_reg <= '0;
                    word_reg  <= '0;
                end else begin
                    if (take_bit) begin
                        shift_reg <= {shift_reg[ADC_BITS-2:0], spi_miso};
                    end
                    if (load_out) begin
                        word_reg <= shift_reg;
                    end
                end
            end
        end
    endgenerate

    assign adc_ch0 = g_chan[0].word_reg;
    assign adc_ch1 = g_chan[1].word_reg;

endmodule

// File: doc/adc_capture.md
# adc_capture

Capture engine for the dual-channel 14-bit ADC that digitises the output of the programmable preamplifier. After the amplifier gain has been loaded over the shared SPI bus, a controller pulses `adc_trig`. The block then:
- issues the ADC conversion strobe,
- clocks out the 34-bit serial frame,
- deserialises both channels,
- presents them as signed words with a one-cycle valid strobe.

It sits directly downstream of the amplifier gain-load block and shares its SCK line through an external mux.

## Interface

Parameters:
- `SCK_HALF`, default 2: SCK half-period in `CLK50MHZ` cycles. Legal range is ≥1. Default gives 12.5 MHz SCK.
- `FRAME_LEN`, default 34: SCK periods per conversion frame. Fixed by the ADC; not to be overridden.

Ports:
- `CLK50MHZ` input, 1: the only clock. All logic is rising-edge.
- `RST` input, 1: reset, asynchronous, active-low.
- `amp_ready` input, 1: high once the preamp gain is loaded. Triggers are ignored while it is low.
- `adc_trig` input, 1: single-cycle request to start one conversion.
- `adc_busy` output, 1: high from trigger acceptance until the cycle after `adc_valid`.
- `adc_valid` output, 1: one-cycle strobe; `adc_ch0`/`adc_ch1` are updated in the same cycle.
- `adc_ch0` output, 14: channel-0 result, two's complement, MSB first on the wire.
- `adc_ch1` output, 14: channel-1 result, two's complement.
- `adc_conv` output, 1: ADC conversion strobe, active-high.
- `spi_sck` output, 1: serial clock, idles low.
- `spi_miso` input, 1: ADC serial data. The ADC changes it on SCK falling edges.

## Operation

- State machine `IDLE → CONV → SHIFT → DONE → IDLE`.
- **IDLE:** `adc_busy=0`, `spi_sck=0`, `adc_conv=0`. A trigger is accepted only when `adc_trig & amp_ready`; the next state is CONV.
- **CONV:** `adc_conv=1` for exactly 2·`SCK_HALF` cycles, with SCK held low. Then go to SHIFT with the bit counter at 0.
- **SHIFT:** SCK toggles every `SCK_HALF` cycles, starting low.
  - `spi_miso` is sampled in the cycle where internal SCK goes high.
  - The bit counter runs 0..33. Bits 0–1 are discarded.
  - Bits 2–15 form ch0, MSB first.
  - Bits 16–17 are discarded.
  - Bits 18–31 form ch1, MSB first.
  - Bits 32–33 are discarded.
  - After the falling edge of SCK period 33, go to DONE.
- **DONE:** for one cycle, copy both shift registers to `adc_ch0`/`adc_ch1` and pulse `adc_valid=1`. Return to IDLE.
- Output registers hold their value until the next DONE. A partially received frame never reaches the outputs.
- `adc_trig` is ignored while busy, including in the DONE cycle. A trigger coincident with `RST` low is lost.
- `amp_ready` falling mid-frame has no effect; the current frame completes.
- **Reset, at any time:** asynchronous return to IDLE. Reset values:
  - `adc_ch0=0`, `adc_ch1=0`
  - `adc_valid=0`, `adc_busy=0`
  - `adc_conv=0`, `spi_sck=0`
  - SCK divider counter and bit counter cleared.
  - An aborted frame produces no `adc_valid`.

## Timing

- All outputs are registered; there are no combinational paths from input to output.
- Let the trigger be accepted on edge 0, and H = `SCK_HALF`.
  - `adc_busy` and `adc_conv` rise on edge 1.
  - `adc_conv` falls on edge 2H+1.
  - The first SCK rising edge is at edge 3H+1.
  - SCK period k rises at 2H+1+H+2Hk.
  - The last falling edge is at 2H+1+68H.
  - `adc_valid` is high for the cycle after edge 70H+1.
  - `adc_busy` falls one cycle after that.
- With H=2: `adc_valid` at edge 141, and the trigger-to-trigger minimum is 143 cycles.
- The SCK duty cycle is exactly 50%.

## Structure

- Shared package `adc_pkg` holds:
  - `ADC_BITS=14` and `ADC_FRAME_LEN=34`
  - bit offsets `CH0_FIRST=2`, `CH1_FIRST=18`
  - the state enum
- One sub-module, `adc_sck_gen`. It is an enableable divider that produces `sck`, `rise_tick` and `fall_tick` from `CLK50MHZ` with `SCK_HALF` as a parameter, and is held in reset while not in SHIFT.
- Counters and shift registers live in `adc_capture`.

## Test plan

1. **Basic frame:** an ADC model drives ch0=14'h2000 and ch1=14'h1FFF, with 1s on all discarded bits. Trigger once. Required: `adc_ch0=-8192` and `adc_ch1=+8191` at edge 141 (H=2), `adc_valid` high for exactly 1 cycle, and exactly 34 SCK rising edges.
2. **Gating:** pulse `adc_trig` with `amp_ready=0`. Required: no `adc_conv`, no SCK, `adc_busy` stays 0. Raise `amp_ready` and trigger. Required: normal frame.
3. **Busy trigger:** re-pulse `adc_trig` at edges 50 and 141. Required: both ignored; only one `adc_valid`, and the outputs keep the first frame's values.
4. **Reset mid-frame:** drive `RST` low at edge 80 for 3 cycles. Required: all outputs at reset values immediately and no `adc_valid`. A subsequent trigger with ch0=14'h0005 and ch1=14'h3FFB gives +5/−5.
5. **Back-to-back frames:** trigger at the earliest legal cycle after `adc_busy` falls. Frame 1 is 14'h0001/14'h0002; frame 2 is 14'h3FFF/14'h0000. Required: results 1/2, then −1/0; `adc_conv` pulses are exactly 4 cycles wide.
6. **Parameter sweep:** with `SCK_HALF=1` and `SCK_HALF=5`, repeat scenario 1. Required: `adc_valid` at edge 70H+1, i.e. 71 and 351.
